// File: rtl/axil_wr_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Package     : pkg_axil_arb
// Description : Shared types and helpers for the AXI-Lite write-channel
//               arbiter. It provides the arbiter state encoding and a
//               one-hot to index converter for vectors of up to 32 bits.
// Revision    : 1.0 - initial release
// ============================================================================
package pkg_axil_arb;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ADDR_DATA = 2'd1,
    RESP      = 2'd2
  } arb_state_t;

  // The input is one-hot, so ORing the indices of the set bits gives the
  // index directly and needs no priority chain.
  function automatic logic [4:0] onehot2idx(input logic [31:0] oh);
    logic [4:0] idx;
    idx = '0;
    for (int i = 0; i < 32; i++) begin
      if (oh[i]) idx = idx | 5'(i);
    end
    return idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/axil_prio_enc.sv
`default_nettype none
// ============================================================================
// Module      : axil_prio_enc
// Description : Combinational rotating priority encoder. The search starts at
//               base_i and wraps modulo NUMBER_MASTER. The first set request
//               bit wins. A base of 0 gives fixed lowest-index priority.
// Ports       : req_i     - request vector
//               base_i    - index where the search starts
//               win_o     - one-hot winner, all-zero when no request
//               win_idx_o - index of the winner, 0 when no request
// Revision    : 1.0 - initial release
// ============================================================================
module axil_prio_enc
  import pkg_axil_arb::*;
#(
  parameter  int NUMBER_MASTER = 32,
  localparam int IDX_W         = $clog2(NUMBER_MASTER)
) (
  input  logic [NUMBER_MASTER-1:0] req_i,
  input  logic [IDX_W-1:0]         base_i,
  output logic [NUMBER_MASTER-1:0] win_o,
  output logic [IDX_W-1:0]         win_idx_o
);

  logic        found;
  logic [31:0] win32;

  always_comb begin : p_search
    int pos;
    pos   = 0;
    win_o = '0;
    found = 1'b0;
    for (int k = 0; k < NUMBER_MASTER; k++) begin
      pos = (int'(base_i) + k) % NUMBER_MASTER;
      if (!found && req_i[IDX_W'(pos)]) begin
        win_o[IDX_W'(pos)] = 1'b1;
        found              = 1'b1;
      end
    end
  end

  assign win32     = 32'(win_o);
  assign win_idx_o = IDX_W'(onehot2idx(win32));

endmodule
`default_nettype wire

// File: rtl/axil_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : axil_wr_arbiter
// Description : Write-channel arbiter for one slave port of an AXI-Lite
//               interconnect. It grants one requesting master and holds the
//               grant from the AW/W handshakes through the B handshake.
//               It then returns to IDLE for one cycle and re-arbitrates.
//               All outputs are registered.
// Config      : AXIL_ARB_RR_EN defined   -> round-robin. The search starts
//                                           one past the last winner.
//               AXIL_ARB_RR_EN undefined -> fixed priority. Master 0 has the
//                                           highest priority.
// Ports       : aclk, aresetn (sync, active low)
//               req_i       - per-master AWVALID decoded to this slave
//               aw_hs_i     - slave AW handshake
//               w_hs_i      - slave W handshake
//               b_hs_i      - slave B handshake
//               grant_o     - one-hot grant, zero when idle
//               grant_idx_o - granted index, 0 when idle
//               grant_vld_o - a grant is active
//               txn_cnt_o   - completed write transactions, wrapping
// Revision    : 1.0 - initial release
// ============================================================================
module axil_wr_arbiter
  import pkg_axil_arb::*;
#(
  parameter  int NUMBER_MASTER = 32,
  parameter  int CNT_W         = 16,
  localparam int IDX_W         = $clog2(NUMBER_MASTER)
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic [NUMBER_MASTER-1:0] req_i,
  input  logic                     aw_hs_i,
  input  logic                     w_hs_i,
  input  logic                     b_hs_i,
  output logic [NUMBER_MASTER-1:0] grant_o,
  output logic [IDX_W-1:0]         grant_idx_o,
  output logic                     grant_vld_o,
  output logic [CNT_W-1:0]         txn_cnt_o
);

  arb_state_t               state_q, state_d;
  logic [NUMBER_MASTER-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]         grant_idx_q, grant_idx_d;
  logic                     aw_done_q, aw_done_d;
  logic                     w_done_q, w_done_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;

  logic [IDX_W-1:0]         base;
  logic [NUMBER_MASTER-1:0] win;
  logic [IDX_W-1:0]         win_idx;

`ifdef AXIL_ARB_RR_EN
  logic [IDX_W-1:0]         rr_ptr_q, rr_ptr_d;
  assign base = rr_ptr_q;
`else
  assign base = '0;
`endif

  axil_prio_enc #(
    .NUMBER_MASTER (NUMBER_MASTER)
  ) u_prio_enc (
    .req_i     (req_i),
    .base_i    (base),
    .win_o     (win),
    .win_idx_o (win_idx)
  );

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    grant_idx_d = grant_idx_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    cnt_d       = cnt_q;
`ifdef AXIL_ARB_RR_EN
    rr_ptr_d    = rr_ptr_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (|req_i) begin
          state_d     = ADDR_DATA;
          grant_d     = win;
          grant_idx_d = win_idx;
`ifdef AXIL_ARB_RR_EN
          // The next search starts one past this winner, wrapping at the top.
          rr_ptr_d    = (win_idx == IDX_W'(NUMBER_MASTER - 1)) ? '0 : win_idx + 1'b1;
`endif
        end
      end
      ADDR_DATA: begin
        // Sticky flags. The state leaves in the same cycle that completes
        // the pair, whatever the order of the handshakes.
        aw_done_d = aw_done_q | aw_hs_i;
        w_done_d  = w_done_q | w_hs_i;
        if (aw_done_d && w_done_d) state_d = RESP;
      end
      RESP: begin
        if (b_hs_i) begin
          state_d     = IDLE;
          grant_d     = '0;
          grant_idx_d = '0;
          aw_done_d   = 1'b0;
          w_done_d    = 1'b0;
          cnt_d       = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      grant_idx_q <= '0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      cnt_q       <= '0;
`ifdef AXIL_ARB_RR_EN
      rr_ptr_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      grant_idx_q <= grant_idx_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      cnt_q       <= cnt_d;
`ifdef AXIL_ARB_RR_EN
      rr_ptr_q    <= rr_ptr_d;
`endif
    end
  end

  assign grant_o     = grant_q;
  assign grant_idx_o = grant_idx_q;
  assign grant_vld_o = (state_q != IDLE);
  assign txn_cnt_o   = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_axil_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_axil_wr_arbiter
// Description : Scoreboard bench for axil_wr_arbiter. The main instance has
//               4 masters and a 4-bit counter. A second instance has 32
//               masters. Expected grants and counts come from a
//               transaction-level model and are popped by negedge monitors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axil_wr_arbiter;

  localparam int N  = 4;
  localparam int CW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          aresetn;
  logic [N-1:0]  req;
  logic          aw_hs, w_hs, b_hs;
  logic [N-1:0]  grant;
  logic [1:0]    gidx;
  logic          gvld;
  logic [CW-1:0] cnt;

  logic          aresetn2;
  logic [31:0]   req2;
  logic          zero2;
  logic [31:0]   grant2;
  logic [4:0]    gidx2;
  logic          gvld2;
  logic [15:0]   cnt2;

  axil_wr_arbiter #(.NUMBER_MASTER(N), .CNT_W(CW)) u_dut (
    .aclk(clk), .aresetn(aresetn), .req_i(req), .aw_hs_i(aw_hs), .w_hs_i(w_hs),
    .b_hs_i(b_hs), .grant_o(grant), .grant_idx_o(gidx), .grant_vld_o(gvld),
    .txn_cnt_o(cnt)
  );

  axil_wr_arbiter #(.NUMBER_MASTER(32)) u_dut32 (
    .aclk(clk), .aresetn(aresetn2), .req_i(req2), .aw_hs_i(zero2), .w_hs_i(zero2),
    .b_hs_i(zero2), .grant_o(grant2), .grant_idx_o(gidx2), .grant_vld_o(gvld2),
    .txn_cnt_o(cnt2)
  );

  int total = 0;
  int bad   = 0;
  int exp_q[$];
  int cnt_q[$];
  int exp2_q[$];
  int cnt_m = 0;
`ifdef AXIL_ARB_RR_EN
  int ptr_m = 0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Reference arbitration, taken straight from the priority rules.
  function automatic int pick(input logic [N-1:0] r);
    int w;
    w = -1;
`ifdef AXIL_ARB_RR_EN
    for (int k = 0; k < N; k++) begin
      int p;
      p = (ptr_m + k) % N;
      if (w < 0 && ((r >> p) & 4'b0001) != 4'b0000) w = p;
    end
`else
    for (int i = N - 1; i >= 0; i--) begin
      if (((r >> i) & 4'b0001) != 4'b0000) w = i;
    end
`endif
    return w;
  endfunction

  function automatic int lowest32(input logic [31:0] v);
    int w;
    w = -1;
    for (int i = 31; i >= 0; i--) begin
      if (((v >> i) & 32'd1) != 32'd0) w = i;
    end
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mode: 0 random order, 1 W before AW, 2 joint AW+W, 3 holder drops req after AW
  task automatic do_txn(input logic [N-1:0] r, input int mode, input bit rst_in_resp);
    int  w, guard;
    bit  awd, wd;
    req = r;
    w   = pick(r);
    exp_q.push_back(w);
`ifdef AXIL_ARB_RR_EN
    ptr_m = (w + 1) % N;
`endif
    tick();
    @(negedge clk);
    check("grant_latency", 32'(gvld), 32'd1);
    awd = 1'b0; wd = 1'b0; guard = 0;
    while (!(awd && wd)) begin
      if (guard == 0 && mode == 1) begin
        aw_hs = 1'b0; w_hs = 1'b1;
      end else if (guard == 0 && mode == 2) begin
        aw_hs = 1'b1; w_hs = 1'b1;
      end else if (guard == 0 && mode == 3) begin
        aw_hs = 1'b1; w_hs = 1'b0;
        req   = ~(4'b0001 << w);
      end else if (guard > 40) begin
        aw_hs = 1'b1; w_hs = 1'b1;
      end else begin
        aw_hs = ($urandom_range(0, 2) == 0);
        w_hs  = ($urandom_range(0, 2) == 0);
      end
      b_hs = ($urandom_range(0, 3) == 0);
      if (mode != 3 && $urandom_range(0, 2) == 0) req = N'($urandom);
      awd = awd | aw_hs;
      wd  = wd | w_hs;
      tick();
      guard++;
    end
    b_hs = 1'b0;
    repeat ($urandom_range(0, 2)) begin
      aw_hs = ($urandom_range(0, 1) == 1);
      w_hs  = ($urandom_range(0, 1) == 1);
      tick();
    end
    aw_hs = 1'b0; w_hs = 1'b0;
    if (rst_in_resp) begin
      aresetn = 1'b0;
      tick();
      cnt_m = 0;
`ifdef AXIL_ARB_RR_EN
      ptr_m = 0;
`endif
      cnt_q.push_back(0);
      aresetn = 1'b1;
    end else begin
      b_hs = 1'b1;
      tick();
      b_hs  = 1'b0;
      cnt_m = (cnt_m + 1) % (1 << CW);
      cnt_q.push_back(cnt_m);
      @(negedge clk);
      check("grant_drop_after_b", 32'(gvld), 32'd0);
    end
  endtask

  task automatic idle_gap(input int n);
    req = '0;
    repeat (n) tick();
  endtask

  // Monitor for the 4-master instance.
  logic prev_vld = 1'b0;
  int   held     = 0;
  always @(negedge clk) begin
    int e;
    e = 0;
    if (gvld === 1'b1 && prev_vld !== 1'b1) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL grant_unexpected: got idx=%0d expected no grant", gidx);
      end else begin
        e = exp_q.pop_front();
        check("grant_idx", 32'(gidx), 32'(e));
        check("grant_onehot", 32'(grant), 32'd1 << e);
        held = e;
      end
    end else if (gvld === 1'b1) begin
      check("grant_hold", 32'(gidx), 32'(held));
    end else if (gvld === 1'b0) begin
      check("idle_grant_zero", 32'(grant), 32'd0);
      check("idle_idx_zero", 32'(gidx), 32'd0);
    end
    if (gvld === 1'b0 && prev_vld === 1'b1) begin
      if (cnt_q.size() == 0) begin
        total++; bad++;
        $display("FAIL grant_drop_unexpected: got drop with cnt=%0d expected held grant", cnt);
      end else begin
        e = cnt_q.pop_front();
        check("txn_cnt", 32'(cnt), 32'(e));
      end
    end
    prev_vld = gvld;
  end

  // Monitor for the 32-master instance.
  logic prev_vld2 = 1'b0;
  always @(negedge clk) begin
    int e;
    e = 0;
    if (gvld2 === 1'b1 && prev_vld2 !== 1'b1) begin
      if (exp2_q.size() == 0) begin
        total++; bad++;
        $display("FAIL grant32_unexpected: got idx=%0d expected no grant", gidx2);
      end else begin
        e = exp2_q.pop_front();
        check("grant32_idx", 32'(gidx2), 32'(e));
        check("grant32_onehot", grant2, 32'd1 << e);
      end
    end
    prev_vld2 = gvld2;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    aresetn = 1'b0; req = '0; aw_hs = 1'b0; w_hs = 1'b0; b_hs = 1'b0;
    aresetn2 = 1'b0; req2 = '0; zero2 = 1'b0;
    tick(); tick();
    @(negedge clk);
    check("rst_vld", 32'(gvld), 32'd0);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_cnt", 32'(cnt), 32'd0);
    aresetn = 1'b1;

    // Fixed-priority style opening, then the remaining holder moves in.
    do_txn(4'b1010, 0, 1'b0);
    do_txn(4'b1000, 0, 1'b0);
    // Everyone requesting, several rounds.
    repeat (5) do_txn(4'b1111, 0, 1'b0);
    // Handshake orders and a holder drop.
    do_txn(4'b0110, 1, 1'b0);
    do_txn(4'b1001, 2, 1'b0);
    do_txn(4'b0011, 3, 1'b0);
    // Reset while waiting for B, then a fresh request right away.
    do_txn(4'b0110, 0, 1'b1);
    do_txn(4'b0100, 0, 1'b0);
    // Random traffic, long enough to wrap the 4-bit counter.
    for (int t = 0; t < 30; t++) begin
      logic [N-1:0] r;
      r = N'($urandom);
      if (r == '0) r = 4'b0001;
      idle_gap($urandom_range(0, 2));
      do_txn(r, $urandom_range(0, 3), 1'b0);
    end
    idle_gap(2);

    // 32-master instance: single grants after reset.
    aresetn2 = 1'b1;
    for (int t = 0; t < 5; t++) begin
      v = (t == 0) ? 32'h8000_0000 : $urandom;
      if (v == 32'd0) v = 32'h0000_0100;
      req2 = v;
      exp2_q.push_back(lowest32(v));
      tick(); tick();
      req2 = '0; aresetn2 = 1'b0;
      tick();
      aresetn2 = 1'b1;
    end

    repeat (3) tick();
    check("scoreboard_drained", 32'(exp_q.size() + exp2_q.size()), 32'd0);
    check("cnt_queue_drained", 32'(cnt_q.size()), 32'd0);
    check("final_cnt", 32'(cnt), 32'(cnt_m));
    check("cnt32_idle", 32'(cnt2), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
